// File: rtl/sata_dma_stream_router.sv
// Command-driven 1-to-OUTPUTS stream demultiplexer: routes exactly cmd_len+1 words
// from the input stream to one latched destination, then returns to idle.
module sata_dma_stream_router #(
    parameter int unsigned OUTPUTS = 2,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LENW    = 16,
    localparam int unsigned SELW   = $clog2(OUTPUTS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [SELW-1:0]                   cmd_sel,
    input  logic [LENW-1:0]                   cmd_len,
    input  logic                              cmd_val,
    output logic                              cmd_rdy,
    input  logic                              abort,
    input  logic [WIDTH-1:0]                  i_dat,
    input  logic                              i_val,
    output logic                              i_rdy,
    output logic [OUTPUTS-1:0][WIDTH-1:0]     o_dat,
    output logic [OUTPUTS-1:0]                o_val,
    output logic [OUTPUTS-1:0]                o_eop,
    input  logic [OUTPUTS-1:0]                o_rdy,
    output logic                              busy,
    output logic [SELW-1:0]                   cur_sel,
    output logic                              done,
    output logic                              aborted
);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e          state_q;
    logic [SELW-1:0] sel_q;
    logic [LENW-1:0] cnt_q;
    logic            xfer;
    logic            live;
    logic            take;
    logic            sel_ok;

    assign xfer    = (state_q == StXfer);
    assign live    = xfer & ~abort;
    assign cmd_rdy = ~xfer;
    assign busy    = xfer;
    assign cur_sel = sel_q;
    assign sel_ok  = (32'(cmd_sel) < OUTPUTS);
    assign take    = i_val & i_rdy;
    assign o_dat   = {OUTPUTS{i_dat}};

    // Zero-latency steering; abort blocks the handshake in its own cycle.
    always_comb begin
        o_val = '0;
        o_eop = '0;
        i_rdy = live & o_rdy[sel_q];
        if (live) begin
            o_val[sel_q] = i_val;
        end
        if (xfer) begin
            o_eop[sel_q] = (cnt_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            cnt_q   <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_val) begin
                        state_q <= StXfer;
                        // Out-of-range destinations fall back to output 0.
                        sel_q   <= sel_ok ? cmd_sel : '0;
                        cnt_q   <= cmd_len;
                    end
                end
                StXfer: begin
                    if (abort) begin
                        state_q <= StIdle;
                        aborted <= 1'b1;
                    end else if (take) begin
                        if (cnt_q == '0) begin
                            state_q <= StIdle;
                            done    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sata_dma_stream_router.sv
// Bench for sata_dma_stream_router: directed scenarios plus random traffic checked
// against a words-remaining transfer model.
module tb_sata_dma_stream_router;

    localparam int unsigned OUTPUTS = 3;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned LENW    = 4;
    localparam int unsigned SELW    = $clog2(OUTPUTS);

    logic                          clk = 1'b0;
    logic                          reset_n;
    logic [SELW-1:0]               cmd_sel;
    logic [LENW-1:0]               cmd_len;
    logic                          cmd_val;
    logic                          cmd_rdy;
    logic                          abort;
    logic [WIDTH-1:0]              i_dat;
    logic                          i_val;
    logic                          i_rdy;
    logic [OUTPUTS-1:0][WIDTH-1:0] o_dat;
    logic [OUTPUTS-1:0]            o_val;
    logic [OUTPUTS-1:0]            o_eop;
    logic [OUTPUTS-1:0]            o_rdy;
    logic                          busy;
    logic [SELW-1:0]               cur_sel;
    logic                          done;
    logic                          aborted;

    sata_dma_stream_router #(
        .OUTPUTS(OUTPUTS),
        .WIDTH  (WIDTH),
        .LENW   (LENW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cmd_sel (cmd_sel),
        .cmd_len (cmd_len),
        .cmd_val (cmd_val),
        .cmd_rdy (cmd_rdy),
        .abort   (abort),
        .i_dat   (i_dat),
        .i_val   (i_val),
        .i_rdy   (i_rdy),
        .o_dat   (o_dat),
        .o_val   (o_val),
        .o_eop   (o_eop),
        .o_rdy   (o_rdy),
        .busy    (busy),
        .cur_sel (cur_sel),
        .done    (done),
        .aborted (aborted)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: an active transfer is (destination, words still owed).
    bit m_busy;
    int m_sel;
    int m_left;
    bit m_done;
    bit m_abt;

    int words [OUTPUTS];
    int done_cnt;
    int abt_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < OUTPUTS; k++) words[k] = 0;
        done_cnt = 0;
        abt_cnt  = 0;
    endtask

    task automatic tick();
        logic [OUTPUTS-1:0] ev;
        logic [OUTPUTS-1:0] ee;
        bit act;
        bit acc;
        @(negedge clk);
        act = m_busy && !abort;
        ev  = '0;
        ee  = '0;
        if (act && i_val) ev[m_sel] = 1'b1;
        if (m_busy && m_left == 1) ee[m_sel] = 1'b1;
        acc = act && i_val && o_rdy[m_sel];
        chk("cmd_rdy", 64'(cmd_rdy), 64'(!m_busy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("i_rdy", 64'(i_rdy), 64'(act && o_rdy[m_sel]));
        chk("o_val", 64'(o_val), 64'(ev));
        chk("o_eop", 64'(o_eop & o_val), 64'(ee & ev));
        chk("done", 64'(done), 64'(m_done));
        chk("aborted", 64'(aborted), 64'(m_abt));
        chk("cur_sel", 64'(cur_sel), 64'(m_sel));
        if (ev != '0) chk("o_dat", 64'(o_dat[m_sel]), 64'(i_dat));
        for (int k = 0; k < OUTPUTS; k++) begin
            if (o_val[k] && o_rdy[k]) words[k]++;
        end
        if (done) done_cnt++;
        if (aborted) abt_cnt++;
        @(posedge clk);
        if (!reset_n) begin
            m_busy = 0; m_sel = 0; m_left = 0; m_done = 0; m_abt = 0;
        end else begin
            m_done = 0;
            m_abt  = 0;
            if (!m_busy) begin
                if (cmd_val) begin
                    m_busy = 1;
                    m_sel  = (int'(cmd_sel) < OUTPUTS) ? int'(cmd_sel) : 0;
                    m_left = int'(cmd_len) + 1;
                end
            end else if (abort) begin
                m_busy = 0;
                m_abt  = 1;
            end else if (acc) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit rn, input bit cv, input int sel, input int len,
                         input bit ab, input bit iv, input logic [OUTPUTS-1:0] ordy);
        reset_n = rn;
        cmd_val = cv;
        cmd_sel = sel[SELW-1:0];
        cmd_len = len[LENW-1:0];
        abort   = ab;
        i_val   = iv;
        o_rdy   = ordy;
        i_dat   = $urandom;
        tick();
    endtask

    initial begin
        reset_n = 0; cmd_val = 0; cmd_sel = '0; cmd_len = '0; abort = 0;
        i_val = 0; i_dat = '0; o_rdy = '0;
        repeat (2) @(posedge clk);
        #1;
        m_busy = 0; m_sel = 0; m_left = 0; m_done = 0; m_abt = 0;
        clr();

        // 1: four words to output 1
        drive(1, 1, 1, 3, 0, 1, 3'b111);
        repeat (4) drive(1, 0, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 0, 0, 0, 0, 3'b111);
        chk("t1_words1", 64'(words[1]), 64'd4);
        chk("t1_words0", 64'(words[0]), 64'd0);
        chk("t1_done", 64'(done_cnt), 64'd1);

        // 2: single word
        clr();
        drive(1, 1, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 0, 0, 0, 0, 3'b111);
        chk("t2_words0", 64'(words[0]), 64'd1);
        chk("t2_done", 64'(done_cnt), 64'd1);

        // 3: backpressure on output 1 only
        clr();
        drive(1, 1, 1, 2, 0, 1, 3'b111);
        drive(1, 0, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 0, 0, 0, 1, 3'b101);
        drive(1, 0, 0, 0, 0, 1, 3'b101);
        drive(1, 0, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 0, 0, 0, 0, 3'b111);
        chk("t3_words1", 64'(words[1]), 64'd3);
        chk("t3_words0", 64'(words[0]), 64'd0);
        chk("t3_done", 64'(done_cnt), 64'd1);

        // 4: abort after two words, then a new command
        clr();
        drive(1, 1, 2, 4, 0, 1, 3'b111);
        repeat (2) drive(1, 0, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 0, 0, 1, 1, 3'b111);
        drive(1, 1, 0, 1, 0, 0, 3'b111);
        chk("t4_words2", 64'(words[2]), 64'd2);
        chk("t4_aborted", 64'(abt_cnt), 64'd1);
        chk("t4_no_done", 64'(done_cnt), 64'd0);
        repeat (2) drive(1, 0, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 0, 0, 0, 0, 3'b111);
        chk("t4_words0", 64'(words[0]), 64'd2);
        chk("t4_done", 64'(done_cnt), 64'd1);

        // 5: reset mid-transfer
        clr();
        drive(1, 1, 1, 7, 0, 1, 3'b111);
        repeat (3) drive(1, 0, 0, 0, 0, 1, 3'b111);
        drive(0, 0, 0, 0, 0, 0, 3'b111);
        repeat (2) drive(1, 0, 0, 0, 0, 0, 3'b111);
        chk("t5_words1", 64'(words[1]), 64'd3);
        chk("t5_no_done", 64'(done_cnt), 64'd0);
        chk("t5_no_abort", 64'(abt_cnt), 64'd0);

        // 6: maximum length
        clr();
        drive(1, 1, 0, 15, 0, 1, 3'b111);
        repeat (16) drive(1, 0, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 0, 0, 0, 1, 3'b111);
        chk("t6_words0", 64'(words[0]), 64'd16);
        chk("t6_done", 64'(done_cnt), 64'd1);

        // illegal destination falls back to output 0
        clr();
        drive(1, 1, 3, 1, 0, 1, 3'b111);
        repeat (2) drive(1, 0, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 0, 0, 0, 0, 3'b111);
        chk("ill_words0", 64'(words[0]), 64'd2);
        chk("ill_words2", 64'(words[2]), 64'd0);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            drive(($urandom % 100) != 0, $urandom % 2, $urandom % 4, $urandom % 16,
                  ($urandom % 25) == 0, ($urandom % 4) != 0, 3'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
